// File: rtl/k3_pkg.sv
// k3_pkg: shared types and constants for the K3 (triangle) colouring blocks.
//   color_t     - one vertex colour, 2 bits
//   coloring_t  - packed triangle colouring {v0, v1, v2}, v0 in bits 5:4
//   k3_state_t  - enumerator FSM states
//   K3_LAST_IDX - last candidate word of the 6-bit search space
package k3_pkg;

  typedef logic [1:0] color_t;

  typedef struct packed {
    color_t v0;
    color_t v1;
    color_t v2;
  } coloring_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } k3_state_t;

  localparam logic [5:0] K3_LAST_IDX = 6'd63;

endpackage

// File: rtl/k3_color_check.sv
// k3_color_check: combinational proper-colouring predicate for a triangle.
//   NUM_COLORS - palette size (1..4); colour c is usable iff c < NUM_COLORS
//   coloring   - candidate colouring {v0, v1, v2}
//   proper     - 1 when all three colours are usable and pairwise distinct
module k3_color_check
  import k3_pkg::*;
#(
  parameter int NUM_COLORS = 4
) (
  input  coloring_t coloring,
  output logic      proper
);

  // Compare at 3 bits so a palette of 4 admits colour 3.
  localparam logic [2:0] NC = 3'(NUM_COLORS);

  logic in_range;
  logic distinct;

  assign in_range = ({1'b0, coloring.v0} < NC) &&
                    ({1'b0, coloring.v1} < NC) &&
                    ({1'b0, coloring.v2} < NC);

  assign distinct = (coloring.v0 != coloring.v1) &&
                    (coloring.v0 != coloring.v2) &&
                    (coloring.v1 != coloring.v2);

  assign proper = in_range && distinct;

endmodule

// File: rtl/k3_coloring_enumerator.sv
// k3_coloring_enumerator: on start, scans all 64 candidate words in ascending
// order and streams every proper K3 colouring over a valid/ready handshake,
// then pulses done for one cycle.
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   start      - begin a run (honoured only in IDLE)
//   busy       - high while scanning or holding an output
//   out_valid  - out_color holds a proper colouring
//   out_ready  - consumer accepts out_color
//   out_color  - {v0, v1, v2}, v0 in bits 5:4
//   count      - colourings accepted this run
//   done       - one-cycle end-of-run pulse
//
// state | meaning
// IDLE  | waiting for start; out_color/count hold last run's values
// SCAN  | test candidate idx, one per cycle
// HOLD  | present proper colouring until accepted
// DONE  | one-cycle done pulse, then back to IDLE
module k3_coloring_enumerator
  import k3_pkg::*;
#(
  parameter int NUM_COLORS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_color,
  output logic [4:0] count,
  output logic       done
);

  k3_state_t  state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] color_q, color_d;
  logic [4:0] count_q, count_d;
  logic       proper;

  k3_color_check #(
    .NUM_COLORS(NUM_COLORS)
  ) u_check (
    .coloring(coloring_t'(idx_q)),
    .proper  (proper)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      color_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    color_d   = color_q;
    count_d   = count_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          count_d = '0;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (proper) begin
          color_d = idx_q;
          state_d = ST_HOLD;
        end else if (idx_q == K3_LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          count_d = count_q + 5'd1;
          if (idx_q == K3_LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_color = color_q;
  assign count     = count_q;

endmodule

// File: tb/tb_k3_coloring_enumerator.sv
module tb_k3_coloring_enumerator;

  logic       clk;
  logic       rst;
  logic       out_ready;
  logic       start_a [3];
  logic       busy_a  [3];
  logic       valid_a [3];
  logic [5:0] color_a [3];
  logic [4:0] count_a [3];
  logic       done_a  [3];

  int n_assert;
  int n_fail;

  // instance 0: palette 4, instance 1: palette 3, instance 2: palette 2
  k3_coloring_enumerator #(.NUM_COLORS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_a[0]), .busy(busy_a[0]),
    .out_valid(valid_a[0]), .out_ready(out_ready), .out_color(color_a[0]),
    .count(count_a[0]), .done(done_a[0])
  );
  k3_coloring_enumerator #(.NUM_COLORS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .busy(busy_a[1]),
    .out_valid(valid_a[1]), .out_ready(out_ready), .out_color(color_a[1]),
    .count(count_a[1]), .done(done_a[1])
  );
  k3_coloring_enumerator #(.NUM_COLORS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .busy(busy_a[2]),
    .out_valid(valid_a[2]), .out_ready(out_ready), .out_color(color_a[2]),
    .count(count_a[2]), .done(done_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    chk({tag, "_busy"},  32'(busy_a[i]),  32'd0);
    chk({tag, "_valid"}, 32'(valid_a[i]), 32'd0);
    chk({tag, "_color"}, 32'(color_a[i]), 32'd0);
    chk({tag, "_count"}, 32'(count_a[i]), 32'd0);
    chk({tag, "_done"},  32'(done_a[i]),  32'd0);
  endtask

  // One full run on instance i. Samples #1 after every edge; c counts edges
  // after the start-sampling edge E.
  task automatic run(input int i, input logic [5:0] exp_q[$], input int exp_done,
                     input bit rnd, input bit poke);
    logic [5:0] got[$];
    logic [5:0] prev_color;
    bit         prev_stall;
    int         acc;
    int         c;
    int         done_c;
    int         first_valid_c;
    acc = 0; c = 0; done_c = -1; first_valid_c = -1;
    prev_stall = 1'b0; prev_color = '0;
    start_a[i] = 1'b1;
    tick;
    start_a[i] = 1'b0;
    for (int k = 0; k < 600; k++) begin
      chk("count_track", 32'(count_a[i]), 32'(acc));
      if (prev_stall) begin
        chk("stall_valid", 32'(valid_a[i]), 32'd1);
        chk("stall_color", 32'(color_a[i]), 32'(prev_color));
      end
      if (done_a[i]) begin
        done_c = c;
        break;
      end
      if (valid_a[i] && first_valid_c < 0) first_valid_c = c;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_a[i] && out_ready) begin
        got.push_back(color_a[i]);
        acc++;
      end
      prev_stall = valid_a[i] && !out_ready;
      prev_color = color_a[i];
      if (poke) start_a[i] = (c == 30);
      tick;
      c++;
    end
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    if (!rnd) begin
      chk("done_cycle", 32'(done_c), 32'(exp_done));
      chk("first_valid", 32'(first_valid_c), (exp_q.size() > 0) ? 32'd7 : 32'hFFFF_FFFF);
    end
    chk("n_out", 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      chk("seq", 32'(got[k]), 32'(exp_q[k]));
    chk("count_final", 32'(count_a[i]), 32'(exp_q.size()));
    out_ready = 1'b1;
    if (poke) start_a[i] = 1'b1;  // coincident with done: must be ignored
    tick;
    start_a[i] = 1'b0;
    chk("done_pulse", 32'(done_a[i]), 32'd0);
    chk("busy_after", 32'(busy_a[i]), 32'd0);
    chk("count_hold", 32'(count_a[i]), 32'(exp_q.size()));
    tick;
    chk("busy_idle", 32'(busy_a[i]), 32'd0);
    chk("color_hold", 32'(color_a[i]),
        (exp_q.size() > 0) ? 32'(exp_q[exp_q.size()-1]) : 32'd0);
  endtask

  initial begin
    logic [5:0] exp4[$];
    logic [5:0] exp3[$];
    logic [5:0] exp2[$];
    int         nval;
    n_assert = 0;
    n_fail   = 0;
    exp4 = '{6'h06, 6'h07, 6'h09, 6'h0B, 6'h0D, 6'h0E,
             6'h12, 6'h13, 6'h18, 6'h1B, 6'h1C, 6'h1E,
             6'h21, 6'h23, 6'h24, 6'h27, 6'h2C, 6'h2D,
             6'h31, 6'h32, 6'h34, 6'h36, 6'h38, 6'h39};
    exp3 = '{6'h06, 6'h09, 6'h12, 6'h18, 6'h21, 6'h24};
    exp2 = {};

    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) check_reset_vals(i, "reset");
    rst = 1'b0;
    tick;
    tick;

    run(0, exp4, 88, 1'b0, 1'b1);
    run(1, exp3, 70, 1'b0, 1'b0);
    run(2, exp2, 64, 1'b0, 1'b0);
    run(0, exp4, 0, 1'b1, 1'b0);

    // abort in HOLD at the third output
    nval = 0;
    start_a[0] = 1'b1;
    tick;
    start_a[0] = 1'b0;
    for (int k = 0; k < 100 && nval < 3; k++) begin
      if (valid_a[0]) nval++;
      out_ready = (nval < 3);
      if (nval < 3) tick;
    end
    chk("third_reached", 32'(nval), 32'd3);
    chk("third_color", 32'(color_a[0]), 32'h09);
    chk("third_count", 32'(count_a[0]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals(0, "async_rst");
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_rst_done", 32'(done_a[0]), 32'd0);
      chk("post_rst_busy", 32'(busy_a[0]), 32'd0);
    end
    run(0, exp4, 88, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
